// File: rtl/register_sequencer.sv
// rtl/register_sequencer.sv - expands op requests into a per-cycle command stream for a 4-bit command register
module register_sequencer #(
    parameter int WIDTH   = 4,
    parameter int COUNT_W = 2
) (
    input  logic               clockSequencer,
    input  logic               resetSequencer,
    input  logic               requestValid,
    output logic               requestReady,
    input  logic [2:0]         requestOp,
    input  logic [WIDTH-1:0]   requestData,
    input  logic [COUNT_W-1:0] requestCount,
    output logic [2:0]         comandOut,
    output logic [WIDTH-1:0]   dataOut,
    output logic [WIDTH-1:0]   shadowValue,
    output logic               donePulse,
    output logic               errorPulse
);

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;

    // Register command encodings
    localparam logic [2:0] CMD_HOLD  = 3'b000;
    localparam logic [2:0] CMD_RESET = 3'b001;
    localparam logic [2:0] CMD_LOAD  = 3'b010;
    localparam logic [2:0] CMD_SHL   = 3'b011;
    localparam logic [2:0] CMD_SHR   = 3'b100;

    // Request op encodings
    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_CLEAR = 3'b001;
    localparam logic [2:0] OP_LOAD  = 3'b010;
    localparam logic [2:0] OP_SHL   = 3'b011;
    localparam logic [2:0] OP_SHR   = 3'b100;

    logic [1:0]         state;
    logic [COUNT_W-1:0] remaining;

    // Ready is decoded straight from state so a requester sees it in the same cycle as donePulse
    assign requestReady = (state == ST_IDLE);

    // Shadow register: follows the command/data pair the real register samples on this same edge
    always_ff @(posedge clockSequencer) begin
        if (resetSequencer) begin
            shadowValue <= '0;
        end else begin
            case (comandOut)
                CMD_RESET: shadowValue <= '0;
                CMD_LOAD:  shadowValue <= dataOut;
                CMD_SHL:   shadowValue <= {shadowValue[WIDTH-2:0], 1'b0};
                CMD_SHR:   shadowValue <= {1'b0, shadowValue[WIDTH-1:1]};
                default:   shadowValue <= shadowValue;
            endcase
        end
    end

    // Sequencer FSM: INIT guarantees one RESET cycle after reset release, ISSUE repeats a command remaining+1 times
    always_ff @(posedge clockSequencer) begin
        if (resetSequencer) begin
            state      <= ST_INIT;
            comandOut  <= CMD_RESET;
            dataOut    <= '0;
            donePulse  <= 1'b0;
            errorPulse <= 1'b0;
            remaining  <= '0;
        end else begin
            donePulse  <= 1'b0;
            errorPulse <= 1'b0;
            case (state)
                ST_INIT: begin
                    comandOut <= CMD_HOLD;
                    state     <= ST_IDLE;
                end
                ST_IDLE: begin
                    comandOut <= CMD_HOLD;
                    if (requestValid) begin
                        case (requestOp)
                            OP_NOP: begin
                                donePulse <= 1'b1;
                            end
                            OP_CLEAR: begin
                                comandOut <= CMD_RESET;
                                remaining <= '0;
                                state     <= ST_ISSUE;
                            end
                            OP_LOAD: begin
                                comandOut <= CMD_LOAD;
                                dataOut   <= requestData;
                                remaining <= '0;
                                state     <= ST_ISSUE;
                            end
                            OP_SHL: begin
                                comandOut <= CMD_SHL;
                                remaining <= requestCount;
                                state     <= ST_ISSUE;
                            end
                            OP_SHR: begin
                                comandOut <= CMD_SHR;
                                remaining <= requestCount;
                                state     <= ST_ISSUE;
                            end
                            default: begin
                                errorPulse <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_ISSUE: begin
                    if (remaining != '0) begin
                        remaining <= remaining - 1'b1;
                    end else begin
                        comandOut <= CMD_HOLD;
                        donePulse <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    comandOut <= CMD_HOLD;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
